// File: rtl/fft_mdc_pkg.sv
// Shared helpers for the MDC FFT reorder logic.
//   fft_log2n(n) : log2 of the FFT size
//   fft_half(n)  : half the FFT size (pairs per 2-lane frame)
//   bitrev(v, w) : reverse the low w bits of v (upper bits cleared)
//   rd_state_e   : read-side FSM state encoding
package fft_mdc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

    function automatic int unsigned fft_log2n(input int unsigned n_fft);
        return $clog2(n_fft);
    endfunction

    function automatic int unsigned fft_half(input int unsigned n_fft);
        return n_fft / 2;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] res;
        res = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                res[5'(i)] = value[5'(width - 1 - i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mdc2p_out_reorder_if.sv
// 2-lane complex sample bus used on both sides of the output reorder block.
//   valid            : pair valid
//   sof              : first pair of a frame (driven by the master, ignored by the reorder input)
//   data1_r/data1_i  : lane-1 complex sample
//   data2_r/data2_i  : lane-2 complex sample
interface mdc2p_out_reorder_if #(
    parameter int unsigned NB = 11
) ();

    logic                 valid;
    logic                 sof;
    logic signed [NB-1:0] data1_r;
    logic signed [NB-1:0] data1_i;
    logic signed [NB-1:0] data2_r;
    logic signed [NB-1:0] data2_i;

    modport master (
        output valid, sof, data1_r, data1_i, data2_r, data2_i
    );

    modport slave (
        input valid, data1_r, data1_i, data2_r, data2_i
    );

endinterface

// File: rtl/mdc2p_reorder_bank.sv
// One ping-pong bank of N_FFT complex words, split into lower (index < HALF)
// and upper halves. Two write ports, each routed to a half by its index MSB;
// two combinational read ports, one per half.
//   i_clk                  : clock
//   i_we0/i_widx0/i_wdata0 : write port 0 (full index, packed {re, im})
//   i_we1/i_widx1/i_wdata1 : write port 1
//   i_raddr_lo/o_rdata_lo_c: read lower-half entry
//   i_raddr_hi/o_rdata_hi_c: read upper-half entry
module mdc2p_reorder_bank import fft_mdc_pkg::*; #(
    parameter int unsigned N_FFT = 16,
    parameter int unsigned DW    = 22,
    localparam int unsigned LOG2N = fft_log2n(N_FFT),
    localparam int unsigned HW    = LOG2N - 1
) (
    input  logic             i_clk,
    input  logic             i_we0,
    input  logic [LOG2N-1:0] i_widx0,
    input  logic [DW-1:0]    i_wdata0,
    input  logic             i_we1,
    input  logic [LOG2N-1:0] i_widx1,
    input  logic [DW-1:0]    i_wdata1,
    input  logic [HW-1:0]    i_raddr_lo,
    output logic [DW-1:0]    o_rdata_lo_c,
    input  logic [HW-1:0]    i_raddr_hi,
    output logic [DW-1:0]    o_rdata_hi_c
);

    localparam int unsigned HALF = fft_half(N_FFT);

    logic [DW-1:0] lo_mem [HALF];
    logic [DW-1:0] hi_mem [HALF];

    // Storage only; contents survive reset by design.
    always_ff @(posedge i_clk) begin
        if (i_we0) begin
            if (i_widx0[LOG2N-1]) begin
                hi_mem[i_widx0[HW-1:0]] <= i_wdata0;
            end else begin
                lo_mem[i_widx0[HW-1:0]] <= i_wdata0;
            end
        end
        if (i_we1) begin
            if (i_widx1[LOG2N-1]) begin
                hi_mem[i_widx1[HW-1:0]] <= i_wdata1;
            end else begin
                lo_mem[i_widx1[HW-1:0]] <= i_wdata1;
            end
        end
    end

    assign o_rdata_lo_c = lo_mem[i_raddr_lo];
    assign o_rdata_hi_c = hi_mem[i_raddr_hi];

endmodule

// File: rtl/mdc2p_out_reorder.sv
// Converts the 2-lane bit-reversed output of the last MDC stage into
// natural bin order using two ping-pong banks.
//   i_clk, i_rst_n : clock, async active-low reset
//   in_if (slave)  : lane 1 = index 2k, lane 2 = index 2k+1 of a bit-reversed frame
//   out_if (master): lane 1 = bin 2m, lane 2 = bin 2m+1; sof on m = 0; all registered
module mdc2p_out_reorder import fft_mdc_pkg::*; #(
    parameter int unsigned N_FFT = 16,
    parameter int unsigned NB    = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mdc2p_out_reorder_if.slave   in_if,
    mdc2p_out_reorder_if.master  out_if
);

    localparam int unsigned LOG2N = fft_log2n(N_FFT);
    localparam int unsigned HALF  = fft_half(N_FFT);
    localparam int unsigned HW    = LOG2N - 1;
    localparam int unsigned DW    = 2 * NB;

    // Write side
    logic [HW-1:0]    k_q;
    logic             wr_bank_q;
    logic             wr_last_c;
    logic [LOG2N-1:0] widx0;
    logic [LOG2N-1:0] widx1;
    logic [DW-1:0]    wdata0;
    logic [DW-1:0]    wdata1;

    // Bank state
    logic [1:0]       full_q;
    logic [1:0]       full_d;

    // Read side
    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [HW-1:0]    m_q;
    logic [HW-1:0]    m_d;
    logic             rd_bank_q;
    logic             rd_bank_d;
    logic             rd_done_c;
    logic [HW-1:0]    rd_addr;
    logic [DW-1:0]    rd_lo_a, rd_hi_a, rd_lo_b, rd_hi_b;
    logic [DW-1:0]    rd_lo, rd_hi;

    assign wr_last_c = in_if.valid && (k_q == HW'(HALF - 1));
    assign widx0     = {k_q, 1'b0};
    assign widx1     = {k_q, 1'b1};
    assign wdata0    = {in_if.data1_r, in_if.data1_i};
    assign wdata1    = {in_if.data2_r, in_if.data2_i};

    // Input pair counter and write-bank pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_q       <= '0;
            wr_bank_q <= 1'b0;
        end else if (in_if.valid) begin
            if (wr_last_c) begin
                k_q       <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else begin
                k_q <= k_q + HW'(1);
            end
        end
    end

    // Full flags: a finished write wins over a same-cycle read release
    always_comb begin
        full_d = full_q;
        if (rd_done_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last_c) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Read FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Read FSM next state; chains straight into the other bank when it is ready
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        rd_bank_d = rd_bank_q;
        rd_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = ST_READ;
                    m_d     = '0;
                end
            end
            ST_READ: begin
                if (m_q == HW'(HALF - 1)) begin
                    rd_done_c = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    m_d       = '0;
                    state_d   = full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
                end else begin
                    m_d = m_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // bitrev over LOG2N bits of 2m equals bitrev over LOG2N-1 bits of m
    // (with MSB 0), so this is the lower-half address; bin 2m+1 sits at
    // the same offset in the upper half.
    assign rd_addr = HW'(bitrev(32'(m_q), HW));

    mdc2p_reorder_bank #(.N_FFT(N_FFT), .DW(DW)) u_bank_a (
        .i_clk        (i_clk),
        .i_we0        (in_if.valid && !wr_bank_q),
        .i_widx0      (widx0),
        .i_wdata0     (wdata0),
        .i_we1        (in_if.valid && !wr_bank_q),
        .i_widx1      (widx1),
        .i_wdata1     (wdata1),
        .i_raddr_lo   (rd_addr),
        .o_rdata_lo_c (rd_lo_a),
        .i_raddr_hi   (rd_addr),
        .o_rdata_hi_c (rd_hi_a)
    );

    mdc2p_reorder_bank #(.N_FFT(N_FFT), .DW(DW)) u_bank_b (
        .i_clk        (i_clk),
        .i_we0        (in_if.valid && wr_bank_q),
        .i_widx0      (widx0),
        .i_wdata0     (wdata0),
        .i_we1        (in_if.valid && wr_bank_q),
        .i_widx1      (widx1),
        .i_wdata1     (wdata1),
        .i_raddr_lo   (rd_addr),
        .o_rdata_lo_c (rd_lo_b),
        .i_raddr_hi   (rd_addr),
        .o_rdata_hi_c (rd_hi_b)
    );

    assign rd_lo = rd_bank_q ? rd_lo_b : rd_lo_a;
    assign rd_hi = rd_bank_q ? rd_hi_b : rd_hi_a;

    // Registered output stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_if.valid   <= 1'b0;
            out_if.sof     <= 1'b0;
            out_if.data1_r <= '0;
            out_if.data1_i <= '0;
            out_if.data2_r <= '0;
            out_if.data2_i <= '0;
        end else begin
            out_if.valid <= (state_q == ST_READ);
            out_if.sof   <= (state_q == ST_READ) && (m_q == '0);
            if (state_q == ST_READ) begin
                out_if.data1_r <= rd_lo[DW-1:NB];
                out_if.data1_i <= rd_lo[NB-1:0];
                out_if.data2_r <= rd_hi[DW-1:NB];
                out_if.data2_i <= rd_hi[NB-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mdc2p_out_reorder.sv
// Bench for mdc2p_out_reorder: drives bit-reversed 2-lane frames, keeps a
// bin-level model of the expected natural-order output stream keyed by
// clock edge, and compares every cycle.
module tb_mdc2p_out_reorder;

    localparam int N     = 16;
    localparam int HALF  = 8;
    localparam int LOG2N = 4;
    localparam int NB    = 11;

    typedef logic signed [NB-1:0] smp_t;
    typedef struct {
        bit   sof;
        smp_t d1r, d1i, d2r, d2i;
    } pair_t;
    typedef struct {
        int   cyc;
        bit   sof;
        smp_t d1r, d1i, d2r, d2i;
    } obs_t;

    logic clk;
    logic rst_n;

    mdc2p_out_reorder_if #(.NB(NB)) in_if ();
    mdc2p_out_reorder_if #(.NB(NB)) out_if ();

    mdc2p_out_reorder #(.N_FFT(N), .NB(NB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .in_if   (in_if),
        .out_if  (out_if)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_in_edge = 0;

    pair_t exp_map [int];
    obs_t  log_q [$];
    obs_t  t1_log [$];
    obs_t  ob;
    pair_t ep;
    pair_t ep_new;
    smp_t  samp_r [N];
    smp_t  samp_i [N];
    smp_t  bin_r [N];
    smp_t  bin_i [N];
    int    mk = 0;
    int    next_free = 0;
    int    fstart;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    function automatic int tb_bitrev(input int v, input int w);
        int r;
        r = 0;
        for (int i = 0; i < w; i++) begin
            if ((v >> i) & 1) r = r | (1 << (w - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: collect a frame, place samples at their bins, schedule pairs.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mk = 0;
            next_free = 0;
            exp_map.delete();
        end else if (in_if.valid === 1'b1) begin
            samp_r[2*mk]   = in_if.data1_r;
            samp_i[2*mk]   = in_if.data1_i;
            samp_r[2*mk+1] = in_if.data2_r;
            samp_i[2*mk+1] = in_if.data2_i;
            if (mk == HALF - 1) begin
                for (int j = 0; j < N; j++) begin
                    bin_r[tb_bitrev(j, LOG2N)] = samp_r[j];
                    bin_i[tb_bitrev(j, LOG2N)] = samp_i[j];
                end
                fstart = (cyc + 2 > next_free) ? cyc + 2 : next_free;
                for (int m = 0; m < HALF; m++) begin
                    ep_new.sof = (m == 0);
                    ep_new.d1r = bin_r[2*m];
                    ep_new.d1i = bin_i[2*m];
                    ep_new.d2r = bin_r[2*m+1];
                    ep_new.d2i = bin_i[2*m+1];
                    exp_map[fstart + m] = ep_new;
                end
                next_free = fstart + HALF;
                mk = 0;
            end else begin
                mk = mk + 1;
            end
        end
    end

    // Per-cycle compare and output log
    always @(posedge clk) begin
        #1;
        if (exp_map.exists(cyc)) begin
            ep = exp_map[cyc];
            exp_map.delete(cyc);
            chk("o_valid", out_if.valid, 1);
            chk("o_sof", out_if.sof, ep.sof);
            chk("o_data1_r", out_if.data1_r, ep.d1r);
            chk("o_data1_i", out_if.data1_i, ep.d1i);
            chk("o_data2_r", out_if.data2_r, ep.d2r);
            chk("o_data2_i", out_if.data2_i, ep.d2i);
        end else begin
            chk("o_valid idle", out_if.valid, 0);
            chk("o_sof idle", out_if.sof, 0);
        end
        if (out_if.valid === 1'b1) begin
            ob.cyc = cyc;
            ob.sof = out_if.sof;
            ob.d1r = out_if.data1_r;
            ob.d1i = out_if.data1_i;
            ob.d2r = out_if.data2_r;
            ob.d2i = out_if.data2_i;
            log_q.push_back(ob);
        end
    end

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_if.valid = 1'b0;
        end
    endtask

    task automatic drive_pair(input smp_t a, input smp_t b, input smp_t c, input smp_t d);
        @(negedge clk);
        in_if.valid   = 1'b1;
        in_if.data1_r = a;
        in_if.data1_i = b;
        in_if.data2_r = c;
        in_if.data2_i = d;
        last_in_edge  = cyc + 1;
    endtask

    function automatic smp_t ext_val();
        return ($urandom_range(0, 1) == 1) ? smp_t'(1023) : smp_t'(-1024);
    endfunction

    // mode 0: re=bin, im=-bin; 1: 100f+bin; 2: extremes; 3: random
    // gap 0: contiguous; 1: every other cycle; 2: random 0..2 idle cycles
    task automatic send_frame(input int f, input int mode, input int gap);
        smp_t v [4];
        for (int k = 0; k < HALF; k++) begin
            int ng;
            ng = (gap == 1) ? ((k == 0) ? 0 : 1) : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
            drive_idle(ng);
            for (int l = 0; l < 2; l++) begin
                int bin;
                bin = tb_bitrev(2*k + l, LOG2N);
                case (mode)
                    0: begin v[2*l] = smp_t'(bin); v[2*l+1] = smp_t'(-bin); end
                    1: begin v[2*l] = smp_t'(100*f + bin); v[2*l+1] = smp_t'(-(100*f + bin)); end
                    2: begin v[2*l] = ext_val(); v[2*l+1] = ext_val(); end
                    default: begin v[2*l] = smp_t'($urandom); v[2*l+1] = smp_t'($urandom); end
                endcase
            end
            drive_pair(v[0], v[1], v[2], v[3]);
        end
    endtask

    initial begin
        int t1_last;
        int t3_last;
        int w;
        rst_n = 1'b0;
        in_if.valid = 1'b0;
        in_if.sof = 1'b0;
        in_if.data1_r = '0;
        in_if.data1_i = '0;
        in_if.data2_r = '0;
        in_if.data2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset o_valid", out_if.valid, 0);
        chk("reset o_sof", out_if.sof, 0);
        chk("reset o_data1_r", out_if.data1_r, 0);
        chk("reset o_data2_i", out_if.data2_i, 0);
        rst_n = 1'b1;
        drive_idle(2);

        // Single contiguous frame, literal expectations
        log_q.delete();
        send_frame(0, 0, 0);
        t1_last = last_in_edge;
        drive_idle(HALF + 6);
        chk("t1 pair count", log_q.size(), HALF);
        if (log_q.size() > 0) chk("t1 latency", log_q[0].cyc - t1_last, 2);
        for (int m = 0; m < log_q.size(); m++) begin
            chk("t1 contiguous", log_q[m].cyc - log_q[0].cyc, m);
            chk("t1 sof", log_q[m].sof, (m == 0));
            chk("t1 lane1 re", log_q[m].d1r, 2*m);
            chk("t1 lane1 im", log_q[m].d1i, -2*m);
            chk("t1 lane2 re", log_q[m].d2r, 2*m + 1);
            chk("t1 lane2 im", log_q[m].d2i, -(2*m + 1));
        end
        t1_log = log_q;

        // Three back-to-back frames
        log_q.delete();
        for (int f = 0; f < 3; f++) send_frame(f, 1, 0);
        drive_idle(2*HALF + 6);
        chk("t2 pair count", log_q.size(), 3*HALF);
        for (int i = 0; i < log_q.size(); i++) begin
            chk("t2 contiguous", log_q[i].cyc - log_q[0].cyc, i);
            chk("t2 sof", log_q[i].sof, ((i % HALF) == 0));
            chk("t2 lane1 re", log_q[i].d1r, 100*(i / HALF) + 2*(i % HALF));
            chk("t2 lane2 re", log_q[i].d2r, 100*(i / HALF) + 2*(i % HALF) + 1);
        end

        // Gapped input: same output as the single frame
        log_q.delete();
        send_frame(0, 0, 1);
        t3_last = last_in_edge;
        drive_idle(HALF + 6);
        chk("t3 pair count", log_q.size(), HALF);
        if (log_q.size() > 0) chk("t3 latency", log_q[0].cyc - t3_last, 2);
        for (int m = 0; m < log_q.size() && m < t1_log.size(); m++) begin
            chk("t3 lane1 re", log_q[m].d1r, t1_log[m].d1r);
            chk("t3 lane1 im", log_q[m].d1i, t1_log[m].d1i);
            chk("t3 lane2 re", log_q[m].d2r, t1_log[m].d2r);
            chk("t3 lane2 im", log_q[m].d2i, t1_log[m].d2i);
            chk("t3 sof", log_q[m].sof, t1_log[m].sof);
        end

        // Extreme values
        log_q.delete();
        send_frame(0, 2, 0);
        send_frame(1, 2, 0);
        drive_idle(HALF + 6);
        chk("t4 pair count", log_q.size(), 2*HALF);

        // Reset during read at m = 3
        send_frame(0, 3, 0);
        w = 0;
        @(negedge clk);
        in_if.valid = 1'b0;
        while (out_if.sof !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t5 sof seen", (w < 50), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5 reset o_valid", out_if.valid, 0);
        chk("t5 reset o_sof", out_if.sof, 0);
        chk("t5 reset o_data1_r", out_if.data1_r, 0);
        chk("t5 reset o_data1_i", out_if.data1_i, 0);
        chk("t5 reset o_data2_r", out_if.data2_r, 0);
        chk("t5 reset o_data2_i", out_if.data2_i, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        send_frame(1, 3, 0);
        drive_idle(HALF + 6);
        chk("t5 pair count", log_q.size(), HALF);

        // Reset during write after 5 pairs
        log_q.delete();
        for (int k = 0; k < 5; k++) drive_pair(smp_t'($urandom), smp_t'($urandom), smp_t'($urandom), smp_t'($urandom));
        @(negedge clk);
        in_if.valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(2, 3, 0);
        drive_idle(HALF + 6);
        chk("t6 pair count", log_q.size(), HALF);

        // Random gaps and data over several frames
        log_q.delete();
        for (int f = 0; f < 4; f++) send_frame(f, 3, 2);
        drive_idle(2*HALF + 6);
        chk("t7 pair count", log_q.size(), 4*HALF);

        chk("pending expectations", exp_map.num(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
